pipe_ctrl: RTL and testbench

- Central sequencing/hazard controller for the 5-stage IF/ID/EX/MEM/WB core.
- Generates per-stage register enables and bubble (flush) controls, resolves RAW and load-use hazards, and redirects the PC on taken branches.
- Implements the debug run/single-step FSM driven by the board step button.
- Keeps stall and flush performance counters for the debug outputs.

---
 rtl/pipe_ctrl_if.sv | 42 ++++
 rtl/pipe_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Stage-side signals shared by the 5-stage datapath and its sequencing controller.
// master = pipe_ctrl (drives enables/forwarding), slave = datapath (drives hazard sources).
interface pipe_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic [4:0] ex_wd;
  logic [4:0] me_wd;
  logic [4:0] wb_wd;
  logic       ex_wr;
  logic       me_wr;
  logic       wb_wr;
  logic       ex_is_load;
  logic       ex_br_taken;
  logic       if_en;
  logic       id_en;
  logic       ex_en;
  logic       me_en;
  logic       wb_en;
  logic       id_flush;
  logic       ex_flush;
  logic       pc_redirect;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  modport master (
    input  id_rs, id_rt, id_use_rs, id_use_rt,
    input  ex_wd, me_wd, wb_wd, ex_wr, me_wr, wb_wr,
    input  ex_is_load, ex_br_taken,
    output if_en, id_en, ex_en, me_en, wb_en,
    output id_flush, ex_flush, pc_redirect, fwd_a, fwd_b
  );

  modport slave (
    output id_rs, id_rt, id_use_rs, id_use_rt,
    output ex_wd, me_wd, wb_wd, ex_wr, me_wr, wb_wr,
    output ex_is_load, ex_br_taken,
    input  if_en, id_en, ex_en, me_en, wb_en,
    input  id_flush, ex_flush, pc_redirect, fwd_a, fwd_b
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller for the IF/ID/EX/MEM/WB core with debug run/step FSM.
// Define PIPE_FORWARD_EN to enable operand forwarding (only load-use then stalls).
module pipe_ctrl #(
  parameter bit START_HALTED = 1'b0,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             step,
  input  logic             dbg_mode,
  pipe_ctrl_if.master      bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             halted
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  localparam state_e RST_STATE = START_HALTED ? ST_HALT : ST_RUN;

  state_e           state_q, state_d;
  logic             halted_q, halted_d;
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             step_pulse, advance, hazard, stall, flush;
  logic             hz_a, hz_b;

  function automatic logic hit(input logic [4:0] r, input logic [4:0] wd, input logic wr);
    return wr && (wd == r) && (r != 5'd0);
  endfunction

  assign step_pulse = sync_q[1] & ~sync_q[2];
  // Gating with aresetn keeps the pipeline frozen for the whole reset, not just after its first edge.
  assign advance    = aresetn & (state_q != ST_HALT);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    hz_a      = 1'b0;
    hz_b      = 1'b0;
    bus.fwd_a = 2'd0;
    bus.fwd_b = 2'd0;
`ifdef PIPE_FORWARD_EN
    hz_a = bus.id_use_rs & bus.ex_is_load & hit(bus.id_rs, bus.ex_wd, bus.ex_wr);
    hz_b = bus.id_use_rt & bus.ex_is_load & hit(bus.id_rt, bus.ex_wd, bus.ex_wr);
    if (aresetn) begin
      if      (hit(bus.id_rs, bus.ex_wd, bus.ex_wr)) bus.fwd_a = 2'd1;
      else if (hit(bus.id_rs, bus.me_wd, bus.me_wr)) bus.fwd_a = 2'd2;
      else if (hit(bus.id_rs, bus.wb_wd, bus.wb_wr)) bus.fwd_a = 2'd3;
      if      (hit(bus.id_rt, bus.ex_wd, bus.ex_wr)) bus.fwd_b = 2'd1;
      else if (hit(bus.id_rt, bus.me_wd, bus.me_wr)) bus.fwd_b = 2'd2;
      else if (hit(bus.id_rt, bus.wb_wd, bus.wb_wr)) bus.fwd_b = 2'd3;
    end
`else
    hz_a = bus.id_use_rs & (hit(bus.id_rs, bus.ex_wd, bus.ex_wr) |
                            hit(bus.id_rs, bus.me_wd, bus.me_wr) |
                            hit(bus.id_rs, bus.wb_wd, bus.wb_wr));
    hz_b = bus.id_use_rt & (hit(bus.id_rt, bus.ex_wd, bus.ex_wr) |
                            hit(bus.id_rt, bus.me_wd, bus.me_wr) |
                            hit(bus.id_rt, bus.wb_wd, bus.wb_wr));
`endif
  end

`ifndef PIPE_FORWARD_EN
  // Without forwarding any in-flight producer stalls, so the load flag carries no information.
  logic unused_is_load;
  assign unused_is_load = bus.ex_is_load;
`endif

  // A taken branch squashes the wrong-path instruction in ID, so it overrides the stall.
  assign hazard = hz_a | hz_b;
  assign stall  = advance & hazard & ~bus.ex_br_taken;
  assign flush  = advance & bus.ex_br_taken;

  assign bus.wb_en       = advance;
  assign bus.me_en       = advance;
  assign bus.ex_en       = advance;
  assign bus.id_en       = advance & ~stall;
  assign bus.if_en       = advance & ~stall;
  assign bus.ex_flush    = stall | flush;
  assign bus.id_flush    = flush;
  assign bus.pc_redirect = flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (dbg_mode) state_d = ST_HALT;
      ST_HALT: begin
        if (!dbg_mode)      state_d = ST_RUN;
        else if (step_pulse) state_d = ST_STEP;
      end
      ST_STEP: state_d = dbg_mode ? ST_HALT : ST_RUN;
      default: state_d = RST_STATE;
    endcase
    halted_d    = (state_d == ST_HALT);
    sync_d      = {sync_q[1:0], step};
    stall_cnt_d = stall_cnt_q + CNT_W'(stall);
    flush_cnt_d = flush_cnt_q + CNT_W'(flush);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!aresetn) begin
      state_q     <= RST_STATE;
      halted_q    <= START_HALTED;
      sync_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      sync_q      <= sync_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed cycles push expected controls, a negedge monitor compares.
// Works for both the default build and a build with PIPE_FORWARD_EN defined.
module tb_pipe_ctrl;
  localparam int CNT_W = 4;
`ifdef PIPE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             aresetn, step, dbg_mode;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             halted;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.START_HALTED(1'b1), .CNT_W(CNT_W)) u_dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .step      (step),
    .dbg_mode  (dbg_mode),
    .bus       (bus),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  typedef enum {K_FRZ, K_ADV, K_STL, K_FLU} kind_e;
  typedef struct {
    string            tag;
    logic [7:0]       ctl;
    logic [1:0]       fa, fb;
    logic             hlt;
    logic [CNT_W-1:0] sc, fc;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  int               n_checks = 0;
  int               n_errors = 0;
  logic [CNT_W-1:0] exp_sc = '0;
  logic [CNT_W-1:0] exp_fc = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {if_en, id_en, ex_en, me_en, wb_en, id_flush, ex_flush, pc_redirect}
  function automatic logic [7:0] ctl_of(input kind_e k);
    case (k)
      K_ADV:   return 8'b11111_000;
      K_STL:   return 8'b00111_010;
      K_FLU:   return 8'b11111_111;
      default: return 8'b00000_000;
    endcase
  endfunction

  task automatic set_idle();
    bus.id_rs = '0; bus.id_rt = '0; bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0;
    bus.ex_wd = '0; bus.me_wd = '0; bus.wb_wd = '0;
    bus.ex_wr = 1'b0; bus.me_wr = 1'b0; bus.wb_wr = 1'b0;
    bus.ex_is_load = 1'b0; bus.ex_br_taken = 1'b0;
  endtask

  // Inputs are already applied; push what this cycle must show, then move to the next cycle.
  task automatic cyc(input string tag, input kind_e k, input logic h,
                     input logic [1:0] fa = 2'd0, input logic [1:0] fb = 2'd0);
    exp_t e;
    e.tag = tag; e.ctl = ctl_of(k); e.fa = fa; e.fb = fb; e.hlt = h;
    e.sc = exp_sc; e.fc = exp_fc;
    sb.push_back(e);
    if (!aresetn) begin
      exp_sc = '0;
      exp_fc = '0;
    end else begin
      if (k == K_STL) exp_sc++;
      if (k == K_FLU) exp_fc++;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check({mon_e.tag, ".ctl"}, {bus.if_en, bus.id_en, bus.ex_en, bus.me_en, bus.wb_en,
                                  bus.id_flush, bus.ex_flush, bus.pc_redirect}, mon_e.ctl);
      check({mon_e.tag, ".fwd_a"}, bus.fwd_a, mon_e.fa);
      check({mon_e.tag, ".fwd_b"}, bus.fwd_b, mon_e.fb);
      check({mon_e.tag, ".halted"}, halted, mon_e.hlt);
      check({mon_e.tag, ".stall_cnt"}, stall_cnt, mon_e.sc);
      check({mon_e.tag, ".flush_cnt"}, flush_cnt, mon_e.fc);
    end
  end

  initial begin
    // Reset with hazard and branch inputs active: everything must stay gated off.
    aresetn = 1'b0; step = 1'b0; dbg_mode = 1'b0;
    set_idle();
    bus.id_rs = 5'd5; bus.id_use_rs = 1'b1; bus.ex_wd = 5'd5; bus.ex_wr = 1'b1;
    bus.ex_is_load = 1'b1; bus.ex_br_taken = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) cyc("rst", K_FRZ, 1'b1);
    set_idle();
    aresetn = 1'b1;
    cyc("rel", K_FRZ, 1'b1);

    // Free run with no writers in flight.
    for (int i = 0; i < 100; i++) begin
      bus.id_rs = 5'($urandom); bus.id_rt = 5'($urandom);
      bus.id_use_rs = 1'($urandom); bus.id_use_rt = 1'($urandom);
      bus.ex_wd = 5'($urandom); bus.me_wd = 5'($urandom); bus.wb_wd = 5'($urandom);
      bus.ex_is_load = 1'($urandom);
      cyc("run", K_ADV, 1'b0);
    end
    check("run_stall_cnt", stall_cnt, 0);
    check("run_flush_cnt", flush_cnt, 0);

    // Load-use on rs, producer walking down the pipe.
    set_idle();
    bus.id_rs = 5'd5; bus.id_use_rs = 1'b1;
    bus.ex_wd = 5'd5; bus.ex_wr = 1'b1; bus.ex_is_load = 1'b1;
    cyc("lu_ex", K_STL, 1'b0, FWD ? 2'd1 : 2'd0);
    bus.ex_wd = '0; bus.ex_wr = 1'b0; bus.ex_is_load = 1'b0;
    bus.me_wd = 5'd5; bus.me_wr = 1'b1;
    cyc("lu_me", FWD ? K_ADV : K_STL, 1'b0, FWD ? 2'd2 : 2'd0);
`ifndef PIPE_FORWARD_EN
    bus.me_wd = '0; bus.me_wr = 1'b0;
    bus.wb_wd = 5'd5; bus.wb_wr = 1'b1;
    cyc("lu_wb", K_STL, 1'b0);
`endif
    set_idle();
    cyc("lu_done", K_ADV, 1'b0);
    check("lu_stall_cnt", stall_cnt, FWD ? 1 : 3);

    // Producer priority on rt.
    set_idle();
    bus.id_rt = 5'd7; bus.id_use_rt = 1'b1;
    bus.ex_wd = 5'd7; bus.me_wd = 5'd7; bus.wb_wd = 5'd7;
    bus.ex_wr = 1'b1; bus.me_wr = 1'b1; bus.wb_wr = 1'b1;
    cyc("pri_ex", FWD ? K_ADV : K_STL, 1'b0, 2'd0, FWD ? 2'd1 : 2'd0);
    bus.ex_wr = 1'b0;
    cyc("pri_me", FWD ? K_ADV : K_STL, 1'b0, 2'd0, FWD ? 2'd2 : 2'd0);
    bus.me_wr = 1'b0;
    cyc("pri_wb", FWD ? K_ADV : K_STL, 1'b0, 2'd0, FWD ? 2'd3 : 2'd0);
    bus.ex_wr = 1'b1; bus.me_wr = 1'b1;
    bus.id_use_rt = 1'b0;
    cyc("pri_nouse", K_ADV, 1'b0, 2'd0, FWD ? 2'd1 : 2'd0);
    bus.id_use_rt = 1'b1;
    bus.id_rt = '0; bus.ex_wd = '0; bus.me_wd = '0; bus.wb_wd = '0;
    cyc("pri_r0", K_ADV, 1'b0);

    // Taken branch beats a simultaneous load-use stall.
    set_idle();
    bus.id_rs = 5'd5; bus.id_use_rs = 1'b1;
    bus.ex_wd = 5'd5; bus.ex_wr = 1'b1; bus.ex_is_load = 1'b1; bus.ex_br_taken = 1'b1;
    cyc("br_lu", K_FLU, 1'b0, FWD ? 2'd1 : 2'd0);

    // 17 more flushes: flush_cnt wraps through 2^CNT_W.
    set_idle();
    bus.ex_br_taken = 1'b1;
    repeat (17) cyc("br_wrap", K_FLU, 1'b0);
    set_idle();
    cyc("post_br", K_ADV, 1'b0);
    check("flush_wrap", flush_cnt, 2);

    // Enter single-step mode; a pending branch must not flush while halted.
    dbg_mode = 1'b1;
    cyc("dbg_enter", K_ADV, 1'b0);
    cyc("dbg_halt", K_FRZ, 1'b1);
    bus.ex_br_taken = 1'b1;
    repeat (3) cyc("halt_frz", K_FRZ, 1'b1);
    set_idle();

    // Two presses, each held 10 cycles: one advance cycle, 4th cycle of the press.
    for (int p = 0; p < 2; p++) begin
      step = 1'b1;
      for (int i = 0; i < 10; i++)
        cyc(p == 0 ? "step1" : "step2", (i == 3) ? K_ADV : K_FRZ, (i == 3) ? 1'b0 : 1'b1);
      step = 1'b0;
      repeat (4) cyc("step_idle", K_FRZ, 1'b1);
    end
    dbg_mode = 1'b0;
    cyc("dbg_exit", K_FRZ, 1'b1);
    cyc("run_again", K_ADV, 1'b0);

    // Reset during STEP with a second step pulse already in the synchronizer.
    dbg_mode = 1'b1;
    cyc("dbg2_enter", K_ADV, 1'b0);
    cyc("dbg2_halt", K_FRZ, 1'b1);
    step = 1'b1; cyc("rs_p0", K_FRZ, 1'b1);
    step = 1'b0; cyc("rs_p1", K_FRZ, 1'b1);
    step = 1'b1; cyc("rs_p2", K_FRZ, 1'b1);
    step = 1'b0; aresetn = 1'b0;
    cyc("rst_step", K_FRZ, 1'b0);
    aresetn = 1'b1;
    repeat (6) cyc("post_rst", K_FRZ, 1'b1);
    check("post_rst_stall_cnt", stall_cnt, 0);
    check("post_rst_flush_cnt", flush_cnt, 0);
    dbg_mode = 1'b0;
    cyc("final_exit", K_FRZ, 1'b1);
    cyc("final_run", K_ADV, 1'b0);

    repeat (2) @(posedge clk);
    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
